// File: rtl/bool_lut_pkg.sv
// Shared constants for the Boolean look-up-table engine.
//   DEF_N_IN  : default number of Boolean input variables
//   DEF_N_OUT : default number of output functions
//   DEF_CNT_W : default width of the completed-transfer counter
//   TBL_W     : truth-table width for the default input count
//   sel_width : width of a function-select field (never below 1)
package bool_lut_pkg;

  localparam int unsigned DEF_N_IN  = 3;
  localparam int unsigned DEF_N_OUT = 3;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned TBL_W     = 2 ** DEF_N_IN;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bool_lut_cell.sv
// One truth-table register plus its read mux.
//   clk, rst_n : clock, asynchronous active-low reset (table clears to 0)
//   we_i       : load wdata_i into the table at the next rising edge
//   wdata_i    : new truth table, bit k is the result for input vector k
//   idx_i      : input vector used to index the table
//   bit_o      : table bit selected by idx_i (combinational read of the
//                registered table, so a same-edge write is not visible)
module bool_lut_cell
  import bool_lut_pkg::*;
#(
  parameter int unsigned N_IN = DEF_N_IN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [2**N_IN-1:0]   wdata_i,
  input  logic [N_IN-1:0]      idx_i,
  output logic                 bit_o
);

  logic [2**N_IN-1:0] tbl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '0;
    end else if (we_i) begin
      tbl_q <= wdata_i;
    end
  end

  assign bit_o = tbl_q[idx_i];

endmodule

// File: rtl/bool_lut_engine.sv
// Evaluates N_OUT programmable Boolean functions of an N_IN-bit input
// vector with one cycle of latency behind a valid/ready handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_we/sel/data     : truth-table write port (out-of-range sel ignored)
//   in_valid/ready/data : input vector stream
//   out_valid/ready/data: evaluated result stream, bit j is function j
//   eval_cnt            : saturating count of completed output transfers
module bool_lut_engine
  import bool_lut_pkg::*;
#(
  parameter int unsigned N_IN  = DEF_N_IN,
  parameter int unsigned N_OUT = DEF_N_OUT,
  parameter int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned SEL_W = sel_width(N_OUT),
  localparam int unsigned TW    = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [TW-1:0]     cfg_data,
  input  logic              in_valid,
  input  logic [N_IN-1:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [N_OUT-1:0]  out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  eval_cnt
);

  logic [N_OUT-1:0] eval_bits;
  logic [N_OUT-1:0] cell_we;
  logic             in_fire;
  logic             out_fire;
  logic             out_valid_q;
  logic [N_OUT-1:0] out_data_q;
  logic [CNT_W-1:0] cnt_q;

  // A select beyond N_OUT-1 matches no cell, so such writes vanish.
  for (genvar j = 0; j < N_OUT; j++) begin : g_cell
    assign cell_we[j] = cfg_we && (cfg_sel == SEL_W'(j));

    bool_lut_cell #(
      .N_IN (N_IN)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (cell_we[j]),
      .wdata_i (cfg_data),
      .idx_i   (in_data),
      .bit_o   (eval_bits[j])
    );
  end

  // The output slot is free when empty or being drained this cycle.
  assign in_ready = ~out_valid_q | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      out_data_q  <= eval_bits;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_fire && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign eval_cnt  = cnt_q;

endmodule

// File: tb/tb_bool_lut_engine.sv
module tb_bool_lut_engine;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_data;
  logic        in_valid;
  logic [2:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [2:0]  out_data;
  logic        out_ready;
  logic [15:0] eval_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [2:0]  out_data4;
  logic [3:0]  eval_cnt4;

  int checks = 0;
  int errors = 0;

  bool_lut_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .eval_cnt  (eval_cnt)
  );

  bool_lut_engine #(
    .CNT_W (4)
  ) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_ready (out_ready),
    .eval_cnt  (eval_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: tables, one result slot, two saturating counters.
  logic [7:0] m_tbl [3];
  logic       m_valid;
  logic [2:0] m_data;
  int         m_cnt;
  int         m_cnt4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) m_tbl[j] = 8'h00;
      m_valid = 1'b0;
      m_data  = 3'd0;
      m_cnt   = 0;
      m_cnt4  = 0;
    end else begin
      bit fi, fo;
      fi = in_valid && (!m_valid || out_ready);
      fo = m_valid && out_ready;
      if (fo) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
      end
      if (fi) begin
        for (int j = 0; j < 3; j++) m_data[j] = m_tbl[j][in_data];
        m_valid = 1'b1;
      end else if (fo) begin
        m_valid = 1'b0;
      end
      if (cfg_we && cfg_sel < 2'd3) m_tbl[cfg_sel] = cfg_data;
    end
  end

  // Results actually handed downstream, in order.
  logic [2:0] cap [$];

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
      chk("eval_cnt", int'(eval_cnt), m_cnt);
      chk("eval_cnt4", int'(eval_cnt4), m_cnt4);
      if (m_valid) chk("out_data", int'(out_data), int'(m_data));
      if (out_valid && out_ready) cap.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input logic [1:0] sel, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_all();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = 3'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_seq(input string nm, input logic [23:0] packed_exp);
    chk({nm, "_len"}, cap.size(), 8);
    for (int k = 0; k < 8 && k < cap.size(); k++)
      chk(nm, int'(cap[k]), int'(packed_exp[k*3 +: 3]));
  endtask

  // T0=CA, T1=8B, T2=28 applied to vectors 0..7: 2,3,0,7,0,4,1,3
  logic [23:0] seq_main;
  logic [23:0] seq_zero;

  initial begin
    seq_main = {3'd3, 3'd1, 3'd4, 3'd0, 3'd7, 3'd0, 3'd3, 3'd2};
    seq_zero = '0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_eval_cnt", int'(eval_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    write_tbl(2'd0, 8'hCA);
    write_tbl(2'd1, 8'h8B);
    write_tbl(2'd2, 8'h28);

    cap.delete();
    send_all();
    check_seq("seq_main", seq_main);
    chk("cnt_after_8", int'(eval_cnt), 8);

    // Back-pressure: result held, second vector refused until drained.
    cap.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3'd5;
    tick();
    in_data = 3'd6;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_data", int'(out_data), 4);
      chk("stall_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("stall_len", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("stall_first", int'(cap[0]), 4);
      chk("stall_second", int'(cap[1]), 1);
    end

    // Table write in the same cycle as an evaluation.
    cap.delete();
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'h00;
    in_valid = 1'b1; in_data = 3'd7;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("wr_len", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("wr_old_bit0", int'(cap[0][0]), 1);
      chk("wr_new_bit0", int'(cap[1][0]), 0);
    end

    // Out-of-range select leaves every table intact.
    write_tbl(2'd0, 8'hCA);
    write_tbl(2'd3, 8'hFF);
    cap.delete();
    send_all();
    check_seq("seq_badsel", seq_main);

    chk("cnt16_total", int'(eval_cnt), 20);
    chk("cnt4_sat", int'(eval_cnt4), 15);
    cap.delete();
    send_all();
    chk("cnt4_stays", int'(eval_cnt4), 15);
    chk("cnt16_more", int'(eval_cnt), 28);

    // Asynchronous reset while a result is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 3'd3;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ready", int'(in_ready), 1);
    chk("async_rst_cnt", int'(eval_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    cap.delete();
    send_all();
    check_seq("seq_cleared", seq_zero);
    chk("cnt_after_rst", int'(eval_cnt), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
